nem_ohmux_sel_seq: RTL and testbench

- Drives the one-hot select lines S0..S(N-1) of the NEM one-hot inverting mux cells (4-input, 8-bit datapath).
- Accepts binary select requests on a valid/ready handshake and enforces relay timing: break-before-make, then a settle dwell.
- Asserts sel_valid once the mux ZN outputs are electrically valid.
- One instance per mux-select group, sitting between the routing/config controller and the relay mux array.

---
 rtl/nem_ohmux_pkg.sv | 26 ++
 rtl/nem_dwell_counter.sv | 28 ++
 rtl/nem_ohmux_sel_seq.sv | 131 +++++++++++++
 tb/tb_nem_ohmux_sel_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nem_ohmux_pkg.sv
// rtl/nem_ohmux_pkg.sv - shared types, defaults and one-hot helper for the NEM mux select sequencer
package nem_ohmux_pkg;

  // Sequencer phases: idle/settled, all-selects-low break, post-assert make dwell
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2
  } state_e;

  // Relay timing defaults, kept in step with the mux characterisation flow
  localparam int DEF_BREAK_CYC = 4;
  localparam int DEF_MAKE_CYC  = 8;

  // Widest select group the one-hot helper can encode
  localparam int ONEHOT_MAX_W = 64;

  // Binary index to one-hot; all-zero when idx is not below n so a bad index never closes a relay
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [ONEHOT_MAX_W-1:0] r;
    r = '0;
    if (idx < n) r = {{(ONEHOT_MAX_W-1){1'b0}}, 1'b1} << idx;
    return r;
  endfunction

endpackage

// File: rtl/nem_dwell_counter.sv
// rtl/nem_dwell_counter.sv - loadable down-counter timing the break and make dwells
module nem_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             CP,
  input  logic             CDN,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over decrement; the count parks at zero once it gets there
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nem_ohmux_sel_seq.sv
// rtl/nem_ohmux_sel_seq.sv - break-before-make one-hot select sequencer for NEM inverting mux cells
module nem_ohmux_sel_seq
  import nem_ohmux_pkg::*;
#(
  parameter  int N_IN      = 4,
  parameter  int BREAK_CYC = DEF_BREAK_CYC,
  parameter  int MAKE_CYC  = DEF_MAKE_CYC,
  parameter  int CNT_W     = 8,
  localparam int SEL_W     = $clog2(N_IN)
) (
  input  logic             CP,
  input  logic             CDN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_en,
  input  logic [SEL_W-1:0] req_sel,
  output logic [N_IN-1:0]  S,
  output logic             sel_valid,
  output logic [SEL_W-1:0] cur_sel,
  output logic             cur_en,
  output logic             err
);

  state_e            state_q;
  logic [N_IN-1:0]   s_q;
  logic              sel_valid_q;
  logic              cur_en_q;
  logic [SEL_W-1:0]  cur_sel_q;
  logic              pend_en_q;
  logic [SEL_W-1:0]  pend_sel_q;
  logic              err_q;

  logic              accept;
  logic              req_in_range;
  logic              eff_en;
  logic              same_tgt;
  logic              go_connect;
  logic              go_break;
  logic              break_to_make;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_en;
  logic              cnt_zero;

  assign accept       = req_valid & (state_q == ST_IDLE);
  assign req_in_range = (32'(req_sel) < 32'(N_IN));
  // An out-of-range connect degrades to a disconnect
  assign eff_en       = req_en & req_in_range;
  assign same_tgt     = eff_en & cur_en_q & (req_sel == cur_sel_q) & sel_valid_q;

  assign go_connect    = accept & eff_en & ~cur_en_q;
  assign go_break      = accept & cur_en_q & ~same_tgt;
  assign break_to_make = (state_q == ST_BREAK) & cnt_zero & pend_en_q;

  assign cnt_load = go_connect | go_break | break_to_make;
  assign cnt_val  = go_break ? CNT_W'(BREAK_CYC - 1) : CNT_W'(MAKE_CYC - 1);
  assign cnt_en   = (state_q != ST_IDLE);

  nem_dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .CP         (CP),
    .CDN        (CDN),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  // Sequencer FSM: all relay-facing outputs are registered and cleared asynchronously
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      sel_valid_q <= 1'b0;
      cur_en_q    <= 1'b0;
      cur_sel_q   <= '0;
      pend_en_q   <= 1'b0;
      pend_sel_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= accept & req_en & ~req_in_range;
      case (state_q)
        ST_IDLE: begin
          if (go_connect) begin
            s_q         <= N_IN'(onehot(32'(req_sel), N_IN));
            cur_sel_q   <= req_sel;
            cur_en_q    <= 1'b1;
            sel_valid_q <= 1'b0;
            state_q     <= ST_MAKE;
          end else if (go_break) begin
            s_q         <= '0;
            sel_valid_q <= 1'b0;
            pend_en_q   <= eff_en;
            pend_sel_q  <= req_sel;
            state_q     <= ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (cnt_zero) begin
            if (pend_en_q) begin
              s_q       <= N_IN'(onehot(32'(pend_sel_q), N_IN));
              cur_sel_q <= pend_sel_q;
              cur_en_q  <= 1'b1;
              state_q   <= ST_MAKE;
            end else begin
              cur_en_q    <= 1'b0;
              sel_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_MAKE: begin
          if (cnt_zero) begin
            sel_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign S         = s_q;
  assign sel_valid = sel_valid_q;
  assign cur_sel   = cur_sel_q;
  assign cur_en    = cur_en_q;
  assign err       = err_q;

endmodule

// File: tb/tb_nem_ohmux_sel_seq.sv
// tb/tb_nem_ohmux_sel_seq.sv - randomized timeline-model bench for nem_ohmux_sel_seq (N_IN=4 and N_IN=3)
module tb_nem_ohmux_sel_seq;

  localparam int B = 4;
  localparam int M = 8;

  logic       CP = 1'b0;
  logic       CDN = 1'b0;
  logic [1:0] rv, re, rr, sv, ce, er;
  logic [1:0] rs0, rs1, cs0, cs1;
  logic [3:0] s0;
  logic [2:0] s1;

  nem_ohmux_sel_seq #(.N_IN(4), .BREAK_CYC(B), .MAKE_CYC(M), .CNT_W(8)) u_dut4 (
    .CP(CP), .CDN(CDN), .req_valid(rv[0]), .req_ready(rr[0]), .req_en(re[0]),
    .req_sel(rs0), .S(s0), .sel_valid(sv[0]), .cur_sel(cs0), .cur_en(ce[0]), .err(er[0])
  );

  nem_ohmux_sel_seq #(.N_IN(3), .BREAK_CYC(B), .MAKE_CYC(M), .CNT_W(8)) u_dut3 (
    .CP(CP), .CDN(CDN), .req_valid(rv[1]), .req_ready(rr[1]), .req_en(re[1]),
    .req_sel(rs1), .S(s1), .sel_valid(sv[1]), .cur_sel(cs1), .cur_en(ce[1]), .err(er[1])
  );

  initial forever #5 CP = ~CP;

  // Edge counter: outputs sampled at negedge reflect edge t
  int t = 0;
  always @(posedge CP) t = t + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d] t=%0d got=%0h exp=%0h", tag, inst, t, got, exp);
  endtask

  // Timeline model: last effective request per instance; kind 0 none, 1 connect, 2 break-first
  int rkind[2];
  int rk[2];
  int rnew_sel[2];
  int rold_sel[2];
  bit rnew_en[2];
  int errk[2];

  function automatic int n_of(int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int m_end(int i);
    if (rkind[i] == 1) return rk[i] + M;
    if (rkind[i] == 2) return rk[i] + B + (rnew_en[i] ? M : 0);
    return -1;
  endfunction

  function automatic bit m_ready(int i);
    return t >= m_end(i);
  endfunction

  function automatic bit m_cur_en(int i);
    if (rkind[i] == 1) return 1'b1;
    if (rkind[i] == 2) return (t < rk[i] + B) ? 1'b1 : rnew_en[i];
    return 1'b0;
  endfunction

  function automatic int m_cur_sel(int i);
    if (rkind[i] == 1) return rnew_sel[i];
    if (rkind[i] == 2) return (t < rk[i] + B) ? rold_sel[i] : rnew_sel[i];
    return 0;
  endfunction

  function automatic int m_s(int i);
    if (rkind[i] == 1) return 1 << rnew_sel[i];
    if (rkind[i] == 2 && rnew_en[i] && t >= rk[i] + B) return 1 << rnew_sel[i];
    return 0;
  endfunction

  function automatic bit m_valid(int i);
    if (rkind[i] == 1) return t >= rk[i] + M;
    if (rkind[i] == 2) return rnew_en[i] && (t >= rk[i] + B + M);
    return 1'b0;
  endfunction

  task automatic m_reset();
    rkind = '{0, 0};
    errk  = '{-1, -1};
  endtask

  // Request accepted at the coming edge t+1; classification uses the settled state after edge t
  task automatic m_accept(input int i, input bit en, input int sel);
    int  k;
    bit  eff;
    k   = t + 1;
    eff = en && (sel < n_of(i));
    if (en && !(sel < n_of(i))) errk[i] = k;
    if (eff && m_cur_en(i) && sel == m_cur_sel(i) && m_valid(i)) return;
    if (!m_cur_en(i) && eff) begin
      rkind[i] = 1; rk[i] = k; rnew_sel[i] = sel; rnew_en[i] = 1'b1;
    end else if (m_cur_en(i)) begin
      rold_sel[i] = m_cur_sel(i);
      rkind[i] = 2; rk[i] = k; rnew_sel[i] = sel; rnew_en[i] = eff;
    end
  endtask

  task automatic check_inst(input int i);
    logic [31:0] s;
    logic        vld, rdy, cen, e;
    logic [1:0]  cs;
    if (i == 0) begin s = 32'(s0); cs = cs0; end
    else        begin s = 32'(s1); cs = cs1; end
    vld = sv[i]; rdy = rr[i]; cen = ce[i]; e = er[i];
    chk("S", i, s, m_s(i));
    chk("sel_valid", i, 32'(vld), 32'(m_valid(i)));
    chk("req_ready", i, 32'(rdy), 32'(m_ready(i)));
    chk("cur_en", i, 32'(cen), 32'(m_cur_en(i)));
    if (m_cur_en(i) || rkind[i] == 0) chk("cur_sel", i, 32'(cs), m_cur_sel(i));
    chk("err", i, 32'(e), 32'(t == errk[i]));
    chk("onehot", i, 32'($countones(s) <= 1), 32'd1);
    chk("valid_inv", i, 32'((!vld) || (rdy && cen)), 32'd1);
  endtask

  typedef struct {int inst; bit en; int sel;} dreq_t;
  dreq_t dq[$];
  bit    rand_mode = 1'b0;

  task automatic drive(input int i, input bit v, input bit en, input int sel);
    rv[i] = v;
    re[i] = en;
    if (i == 0) rs0 = 2'(sel);
    else        rs1 = 2'(sel);
  endtask

  task automatic step();
    @(negedge CP);
    for (int i = 0; i < 2; i++) check_inst(i);
    for (int i = 0; i < 2; i++) begin
      bit v, en;
      int sel;
      v   = 1'b0;
      en  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 3));
      if (CDN) begin
        if (rand_mode) begin
          v  = ($urandom_range(0, 2) == 0);
          en = ($urandom_range(0, 4) != 0);
        end else if (dq.size() > 0 && dq[0].inst == i && m_ready(i)) begin
          v = 1'b1; en = dq[0].en; sel = dq[0].sel;
          void'(dq.pop_front());
        end
        if (v && m_ready(i)) m_accept(i, en, sel);
      end
      drive(i, v, en, sel);
    end
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (c < budget && !(dq.size() == 0 && m_ready(0) && m_ready(1))) begin
      step();
      c++;
    end
    chk("drain", 0, 32'(dq.size()), 32'd0);
  endtask

  int kk;

  initial begin
    rv = '0; re = '0; rs0 = '0; rs1 = '0;
    m_reset();
    repeat (3) step();
    CDN = 1'b1;

    // Directed: connect, change, same-target, disconnect; N_IN=3 invalid index cases
    dq.push_back('{0, 1'b1, 2});
    dq.push_back('{0, 1'b1, 1});
    dq.push_back('{0, 1'b1, 1});
    dq.push_back('{0, 1'b0, 0});
    dq.push_back('{1, 1'b1, 3});
    dq.push_back('{1, 1'b1, 0});
    dq.push_back('{1, 1'b1, 3});
    drain(400);
    repeat (2) step();

    // Reset pulse in MAKE with three cycles of dwell left
    dq.push_back('{0, 1'b1, 1});
    for (int c = 0; c < 20 && dq.size() > 0; c++) step();
    kk = rk[0];
    for (int c = 0; c < 20 && t < kk + 4; c++) step();
    chk("mid_make_S", 0, 32'(s0), 32'h2);
    #2 CDN = 1'b0;
    #1;
    chk("async_S", 0, 32'(s0), 32'd0);
    chk("async_valid", 0, 32'(sv[0]), 32'd0);
    chk("async_ready", 0, 32'(rr[0]), 32'd1);
    #1 CDN = 1'b1;
    m_reset();
    repeat (3) step();

    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
